// File: rtl/tile_result_packer.sv
// Drain for the systolic tile array: buffers result words in a small FIFO and
// streams each as a framed byte sequence (header, then result bytes MSB first).
module tile_result_packer #(
    parameter int          Bitwidth = 16,
    parameter int          Depth    = 8,
    parameter logic [7:0]  Header   = 8'hA5
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [Bitwidth-1:0]      IP,
    input  logic                     IP_valid,
    input  logic                     CLR_OVF,
    output logic [7:0]               TX_data,
    output logic                     TX_valid,
    input  logic                     TX_ready,
    output logic [$clog2(Depth):0]   LEVEL,
    output logic                     OVF,
    output logic [1:0]               FSM_STATE
);

    // Byte handshake: a byte moves on a rising edge where TX_valid && TX_ready;
    // once TX_valid is raised, TX_data and TX_valid hold until that transfer.

    localparam int N  = Bitwidth / 8;
    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(Depth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [Bitwidth-1:0]   mem [Depth];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [Bitwidth-1:0]   shift, shift_n, shifted;
    logic [CW-1:0]         cnt, cnt_n;
    logic [7:0]            tx_data_n;
    logic                  tx_valid_n;
    logic                  tx_fire;
    logic                  fifo_empty, fifo_full;
    logic                  pop, push, drop;

    assign tx_fire    = TX_valid && TX_ready;
    assign fifo_empty = (LEVEL == '0);
    assign fifo_full  = (LEVEL == LEVEL_FULL);
    assign shifted    = shift << 8;
    assign FSM_STATE  = state;

    // A full FIFO still accepts a word on the edge the head is popped.
    assign push = IP_valid && (!fifo_full || pop);
    assign drop = IP_valid && !push;

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        cnt_n      = cnt;
        tx_data_n  = TX_data;
        tx_valid_n = TX_valid;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_valid_n = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_n    = mem[rd_ptr];
                    tx_data_n  = Header;
                    tx_valid_n = 1'b1;
                    state_n    = HDR;
                end
            end
            HDR: begin
                if (tx_fire) begin
                    tx_data_n = shift[Bitwidth-1 -: 8];
                    cnt_n     = CNT_LAST;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tx_fire) begin
                    if (cnt != '0) begin
                        shift_n   = shifted;
                        tx_data_n = shifted[Bitwidth-1 -: 8];
                        cnt_n     = cnt - CW'(1);
                    end else if (!fifo_empty) begin
                        // Next frame starts with no bubble on the link.
                        pop       = 1'b1;
                        shift_n   = mem[rd_ptr];
                        tx_data_n = Header;
                        state_n   = HDR;
                    end else begin
                        tx_valid_n = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            default: begin
                tx_valid_n = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= IP;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            TX_data  <= '0;
            TX_valid <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            cnt      <= cnt_n;
            TX_data  <= tx_data_n;
            TX_valid <= tx_valid_n;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
            OVF    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + LW'(1);
                2'b01:   LEVEL <= LEVEL - LW'(1);
                default: LEVEL <= LEVEL;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                OVF <= 1'b1;
            end else if (CLR_OVF) begin
                OVF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tile_result_packer.sv
// Directed bench for tile_result_packer: framing, latency, backpressure,
// back-to-back frames, overflow/OVF behaviour and full push-with-pop.
module tb_tile_result_packer;

    localparam int BW    = 16;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [BW-1:0] IP;
    logic          IP_valid;
    logic          CLR_OVF;
    logic [7:0]    TX_data;
    logic          TX_valid;
    logic          TX_ready;
    logic [3:0]    LEVEL;
    logic          OVF;
    logic [1:0]    FSM_STATE;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    tile_result_packer #(
        .Bitwidth(BW),
        .Depth   (DEPTH),
        .Header  (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IP       (IP),
        .IP_valid (IP_valid),
        .CLR_OVF  (CLR_OVF),
        .TX_data  (TX_data),
        .TX_valid (TX_valid),
        .TX_ready (TX_ready),
        .LEVEL    (LEVEL),
        .OVF      (OVF),
        .FSM_STATE(FSM_STATE)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        RST_N    = 1'b0;
        IP       = '0;
        IP_valid = 1'b0;
        CLR_OVF  = 1'b0;
        TX_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic push_frame(input logic [15:0] w);
        exp_q.push_back(8'hA5);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Called at a falling edge; returns the next byte that transfers and
    // leaves the caller at the falling edge after that transfer.
    task automatic get_byte(output logic [7:0] b, output bit ok);
        b  = '0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (TX_valid && TX_ready) begin
                b  = TX_data;
                ok = 1'b1;
                @(negedge CLK);
                return;
            end
            @(negedge CLK);
        end
    endtask

    task automatic drain_bytes(input string name);
        logic [7:0] b;
        logic [7:0] e;
        bit         ok;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_byte(b, ok);
            total++;
            if (!ok || b !== e) begin
                bad++;
                $display("FAIL %s byte got=%h (ok=%0d) want=%h", name, b, ok, e);
            end
        end
    endtask

    task automatic drain_idle(input string name);
        bit idle = 1'b0;
        TX_ready = 1'b1;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge CLK);
            idle = !TX_valid && (LEVEL == 4'd0);
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL %s drain_timeout level=%0d tx_valid=%0d want idle", name, LEVEL, TX_valid);
        end
    endtask

    task automatic test_reset();
        int seen;
        RST_N    = 1'b0;
        IP       = '0;
        IP_valid = 1'b0;
        CLR_OVF  = 1'b0;
        TX_ready = 1'b0;
        #1;
        total++;
        if ({TX_data, TX_valid, LEVEL, OVF, FSM_STATE} !== 16'd0) begin
            bad++;
            $display("FAIL reset_initial got data=%h v=%0d lvl=%0d ovf=%0d st=%0d want all 0",
                     TX_data, TX_valid, LEVEL, OVF, FSM_STATE);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IP       = 16'h5000 + 16'(i);
            IP_valid = 1'b1;
            @(negedge CLK);
        end
        IP_valid = 1'b0;
        total++;
        if (LEVEL !== 4'd3 || TX_valid !== 1'b1 || TX_data !== 8'hA5) begin
            bad++;
            $display("FAIL reset_setup got lvl=%0d v=%0d data=%h want 3 1 a5", LEVEL, TX_valid, TX_data);
        end
        RST_N = 1'b0;
        #1;
        total++;
        if ({TX_data, TX_valid, LEVEL, OVF, FSM_STATE} !== 16'd0) begin
            bad++;
            $display("FAIL reset_midframe got data=%h v=%0d lvl=%0d ovf=%0d st=%0d want all 0",
                     TX_data, TX_valid, LEVEL, OVF, FSM_STATE);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N    = 1'b1;
        TX_ready = 1'b1;
        seen     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (TX_valid) seen++;
        end
        total++;
        if (seen !== 0 || LEVEL !== 4'd0) begin
            bad++;
            $display("FAIL reset_no_resume got valid_cycles=%0d lvl=%0d want 0 0", seen, LEVEL);
        end
    endtask

    task automatic test_single();
        logic [7:0] want [3];
        do_reset();
        want[0]  = 8'hA5;
        want[1]  = 8'h12;
        want[2]  = 8'h34;
        TX_ready = 1'b1;
        IP       = 16'h1234;
        IP_valid = 1'b1;
        @(negedge CLK);
        IP_valid = 1'b0;
        total++;
        if (LEVEL !== 4'd1 || TX_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_capture got lvl=%0d v=%0d want 1 0", LEVEL, TX_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (TX_valid !== 1'b1 || TX_data !== want[i] || LEVEL !== 4'd0) begin
                bad++;
                $display("FAIL single_byte%0d got v=%0d data=%h lvl=%0d want 1 %h 0",
                         i, TX_valid, TX_data, LEVEL, want[i]);
            end
        end
        @(negedge CLK);
        total++;
        if (TX_valid !== 1'b0 || FSM_STATE !== 2'd0) begin
            bad++;
            $display("FAIL single_end got v=%0d st=%0d want 0 0", TX_valid, FSM_STATE);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] prev_data  = '0;
        bit         prev_valid = 1'b0;
        bit         prev_fire  = 1'b0;
        bit         fire;
        logic [7:0] e;
        int         extra = 0;
        do_reset();
        push_frame(16'hBEEF);
        IP       = 16'hBEEF;
        IP_valid = 1'b1;
        @(negedge CLK);
        IP_valid = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            if (prev_valid && !prev_fire) begin
                total++;
                if (TX_valid !== 1'b1 || TX_data !== prev_data) begin
                    bad++;
                    $display("FAIL bp_stable got v=%0d data=%h want 1 %h", TX_valid, TX_data, prev_data);
                end
            end
            TX_ready = 1'($urandom_range(0, 1));
            fire     = TX_valid && TX_ready;
            if (fire) begin
                e = exp_q.pop_front();
                total++;
                if (TX_data !== e) begin
                    bad++;
                    $display("FAIL bp_byte got=%h want=%h", TX_data, e);
                end
            end
            prev_data  = TX_data;
            prev_valid = TX_valid;
            prev_fire  = fire;
            @(negedge CLK);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_timeout got remaining=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        TX_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (TX_valid) extra++;
            @(negedge CLK);
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL bp_once got extra_valid=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        bit started = 1'b0;
        logic [7:0] e;
        do_reset();
        push_frame(16'h0001);
        push_frame(16'h0002);
        push_frame(16'h0003);
        TX_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            IP_valid = (cyc < 3);
            IP       = 16'(cyc + 1);
            if (TX_valid) begin
                started = 1'b1;
                e = exp_q.pop_front();
                total++;
                if (TX_data !== e) begin
                    bad++;
                    $display("FAIL b2b_byte got=%h want=%h", TX_data, e);
                end
            end else if (started) begin
                total++;
                bad++;
                $display("FAIL b2b_gap got tx_valid=0 want 1 (remaining=%0d)", exp_q.size());
            end
            @(negedge CLK);
        end
        IP_valid = 1'b0;
        total++;
        if (exp_q.size() != 0 || TX_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got remaining=%0d v=%0d want 0 0", exp_q.size(), TX_valid);
            exp_q.delete();
        end
    endtask

    task automatic fill_ten(input logic [15:0] base);
        TX_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            IP       = base + 16'(i);
            IP_valid = 1'b1;
            @(negedge CLK);
        end
        IP_valid = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        fill_ten(16'h0000);
        total++;
        if (LEVEL !== 4'd8 || OVF !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full got lvl=%0d ovf=%0d want 8 1", LEVEL, OVF);
        end
        for (int i = 1; i <= 9; i++) push_frame(16'(i));
        TX_ready = 1'b1;
        drain_bytes("ovf_order");
        total++;
        if (OVF !== 1'b1 || TX_valid !== 1'b0 || LEVEL !== 4'd0) begin
            bad++;
            $display("FAIL ovf_sticky got ovf=%0d v=%0d lvl=%0d want 1 0 0", OVF, TX_valid, LEVEL);
        end
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        total++;
        if (OVF !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%0d want=0", OVF);
        end
        fill_ten(16'h0100);
        IP       = 16'h01FF;
        IP_valid = 1'b1;
        CLR_OVF  = 1'b1;
        @(negedge CLK);
        IP_valid = 1'b0;
        CLR_OVF  = 1'b0;
        total++;
        if (OVF !== 1'b1 || LEVEL !== 4'd8) begin
            bad++;
            $display("FAIL ovf_drop_beats_clear got ovf=%0d lvl=%0d want 1 8", OVF, LEVEL);
        end
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        total++;
        if (OVF !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear2 got=%0d want=0", OVF);
        end
        drain_idle("ovf");
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        bit         ok;
        do_reset();
        TX_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            IP       = 16'h1100 + 16'(i);
            IP_valid = 1'b1;
            @(negedge CLK);
        end
        IP_valid = 1'b0;
        total++;
        if (LEVEL !== 4'd8 || OVF !== 1'b0) begin
            bad++;
            $display("FAIL full_setup got lvl=%0d ovf=%0d want 8 0", LEVEL, OVF);
        end
        for (int i = 1; i <= 9; i++) push_frame(16'h1100 + 16'(i));
        push_frame(16'h00AA);
        TX_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                IP       = 16'h00AA;
                IP_valid = 1'b1;
            end
            get_byte(b, ok);
            IP_valid = 1'b0;
            total++;
            if (!ok || b !== exp_q[0]) begin
                bad++;
                $display("FAIL full_first_frame byte got=%h (ok=%0d) want=%h", b, ok, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        total++;
        if (LEVEL !== 4'd8 || OVF !== 1'b0 || TX_data !== 8'hA5) begin
            bad++;
            $display("FAIL full_push_pop got lvl=%0d ovf=%0d data=%h want 8 0 a5", LEVEL, OVF, TX_data);
        end
        drain_bytes("full_order");
        drain_idle("full");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
